// File: rtl/simon_iter_core_pkg.sv
// Shared constants, FSM state type and word helpers for the iterative SIMON core.
package simon_pkg;

  // z-sequences, first element of each sequence in the MSB (bit 61)
  localparam logic [61:0] Z_SEQ [0:4] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef enum logic [2:0] {NOKEY, EXPAND, READY, RUN, DONE} state_t;

  // rotate left within an n-bit word carried in a 64-bit container
  function automatic logic [63:0] rol(input logic [63:0] v, input int s, input int n);
    logic [63:0] m, w;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    w = v & m;
    return ((w << s) | (w >> (n - s))) & m;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int s, input int n);
    return rol(v, n - s, n);
  endfunction

  // SIMON round function
  function automatic logic [63:0] simon_f(input logic [63:0] v, input int n);
    return (rol(v, 1, n) & rol(v, 8, n)) ^ rol(v, 2, n);
  endfunction

endpackage

// File: rtl/simon_iter_core_if.sv
// Key, block-in and block-out streams of the SIMON core.
interface simon_iter_core_if #(
  parameter int N_WORD = 32,
  parameter int M_KEYW = 4
);
  logic                       key_valid, key_ready;
  logic [M_KEYW*N_WORD-1:0]   key_in;
  logic                       in_valid, in_ready, in_mode;
  logic [2*N_WORD-1:0]        in_data;
  logic                       out_valid, out_ready;
  logic [2*N_WORD-1:0]        out_data;
  logic                       key_loaded;

  modport master (
    output key_valid, key_in, in_valid, in_mode, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, key_loaded
  );
  modport slave (
    input  key_valid, key_in, in_valid, in_mode, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, key_loaded
  );
endinterface

// File: rtl/simon_iter_core_keystore.sv
// Round-key store: bulk load of the m user key words, one expansion write
// per cycle, NRD combinational read ports.
module simon_keystore #(
  parameter int N_WORD = 32,
  parameter int M_KEYW = 4,
  parameter int ROUNDS = 44,
  parameter int AW     = 6,
  parameter int NRD    = 4
) (
  input  logic                          clk,
  input  logic                          ld,
  input  logic [M_KEYW*N_WORD-1:0]      key,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [N_WORD-1:0]             wdata,
  input  logic [NRD-1:0][AW-1:0]        raddr,
  output logic [NRD-1:0][N_WORD-1:0]    rdata
);
  logic [ROUNDS-1:0][N_WORD-1:0] mem;

  // key load takes precedence; contents need no reset
  always_ff @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < M_KEYW; i++) mem[i] <= key[i*N_WORD +: N_WORD];
    end else if (we && int'(waddr) < ROUNDS) begin
      mem[waddr] <= wdata;
    end
  end

  // out-of-range reads (idle address arithmetic) return zero
  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign rdata[r] = (int'(raddr[r]) < ROUNDS) ? mem[raddr[r]] : '0;
  end
endmodule

// File: rtl/simon_iter_core.sv
// Iterative SIMON 2n/mn core: key expansion, then one round per clock,
// encrypt or decrypt chosen per block.
module simon_iter_core
  import simon_pkg::*;
#(
  parameter int N_WORD = 32,
  parameter int M_KEYW = 4,
  parameter int ROUNDS = 44,
  parameter int Z_IDX  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  simon_iter_core_if.slave   bus
);
  localparam int              CW       = $clog2(ROUNDS);
  localparam logic [CW-1:0]   LAST_RND = CW'(ROUNDS - 1);
  localparam logic [CW-1:0]   LAST_EXP = CW'(ROUNDS - M_KEYW - 1);
  localparam logic [61:0]     ZS       = Z_SEQ[Z_IDX];

  state_t                     state, nstate;
  logic [CW-1:0]              cnt;
  logic [N_WORD-1:0]          x, y;
  logic                       mode, loaded;
  logic                       key_acc, blk_acc;
  logic [3:0][CW-1:0]         raddr;
  logic [3:0][N_WORD-1:0]     rdata;
  logic [N_WORD-1:0]          tmp, knew, rk, f_x, f_y;
  logic [5:0]                 zi;

  // next state and stream readies; a key offered in READY beats a block
  always_comb begin
    nstate        = state;
    bus.key_ready = 1'b0;
    bus.in_ready  = 1'b0;
    case (state)
      NOKEY: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) nstate = EXPAND;
      end
      EXPAND: if (cnt == LAST_EXP) nstate = READY;
      READY: begin
        bus.key_ready = 1'b1;
        bus.in_ready  = !bus.key_valid;
        if (bus.key_valid)     nstate = EXPAND;
        else if (bus.in_valid) nstate = RUN;
      end
      RUN:  if (cnt == LAST_RND) nstate = DONE;
      DONE: if (bus.out_ready) nstate = READY;
      default: nstate = NOKEY;
    endcase
  end

  assign key_acc        = bus.key_valid & bus.key_ready;
  assign blk_acc        = bus.in_valid & bus.in_ready;
  assign bus.out_valid  = (state == DONE);
  assign bus.out_data   = {x, y};
  assign bus.key_loaded = loaded;

  // expansion reads k[i], k[i+1], k[i+m-1]; port 3 is the round key
  assign raddr[0] = cnt;
  assign raddr[1] = cnt + CW'(1);
  assign raddr[2] = cnt + CW'(M_KEYW - 1);
  assign raddr[3] = mode ? (LAST_RND - cnt) : cnt;
  assign rk       = rdata[3];

  // next schedule word and round functions
  always_comb begin
    zi  = 6'(61 - (int'(cnt) % 62));
    tmp = N_WORD'(ror(64'(rdata[2]), 3, N_WORD));
    if (M_KEYW == 4) tmp = tmp ^ rdata[1];
    knew = ~rdata[0] ^ tmp ^ N_WORD'(ror(64'(tmp), 1, N_WORD))
         ^ N_WORD'(ZS[zi]) ^ N_WORD'(3);
    f_x  = N_WORD'(simon_f(64'(x), N_WORD));
    f_y  = N_WORD'(simon_f(64'(y), N_WORD));
  end

  simon_keystore #(
    .N_WORD(N_WORD), .M_KEYW(M_KEYW), .ROUNDS(ROUNDS), .AW(CW), .NRD(4)
  ) u_ks (
    .clk   (clk),
    .ld    (key_acc),
    .key   (bus.key_in),
    .we    (state == EXPAND),
    .waddr (cnt + CW'(M_KEYW)),
    .wdata (knew),
    .raddr (raddr),
    .rdata (rdata)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NOKEY;
    else        state <= nstate;
  end

  // counter, block registers and key-loaded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      mode   <= 1'b0;
      loaded <= 1'b0;
    end else begin
      case (state)
        NOKEY, READY: begin
          if (key_acc) begin
            cnt    <= '0;
            loaded <= 1'b0;
          end else if (blk_acc) begin
            {x, y} <= bus.in_data;
            mode   <= bus.in_mode;
            cnt    <= '0;
          end
        end
        EXPAND: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_EXP) loaded <= 1'b1;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (mode) begin
            x <= y;
            y <= x ^ f_y ^ rk;
          end else begin
            x <= y ^ f_x ^ rk;
            y <= x;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_iter_core.sv
// Directed bench for simon_iter_core: 64/128 and 32/64 vectors, handshake
// timing, backpressure, key priority, mid-run reset and round trips.
module tb_simon_iter_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simon_iter_core_if #(.N_WORD(32), .M_KEYW(4)) bus ();
  simon_iter_core_if #(.N_WORD(16), .M_KEYW(4)) bus16 ();

  simon_iter_core #(.N_WORD(32), .M_KEYW(4), .ROUNDS(44), .Z_IDX(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  simon_iter_core #(.N_WORD(16), .M_KEYW(4), .ROUNDS(32), .Z_IDX(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  localparam logic [127:0] KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT  = 64'h656b696c_20646e75;
  localparam logic [63:0]  CT  = 64'h44c8fc20_b9dfa07a;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k, output int cyc);
    int n = 0;
    @(negedge clk);
    bus.key_in = k; bus.key_valid = 1'b1;
    #1;
    while (!bus.key_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!bus.key_ready) chk("key_hs_timeout", 128'(bus.key_ready), 128'(1));
    @(posedge clk); @(negedge clk);
    bus.key_valid = 1'b0;
    cyc = 0;
    while (!bus.key_loaded && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  task automatic run_blk(input logic m, input logic [63:0] d, input int hold,
                         output logic [63:0] res, output int lat);
    int n = 0;
    @(negedge clk);
    bus.in_data = d; bus.in_mode = m; bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!bus.in_ready) chk("in_hs_timeout", 128'(bus.in_ready), 128'(1));
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    res = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable", {bus.out_valid, bus.in_ready, bus.out_data},
          {1'b1, 1'b0, res});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run16(input logic m, input logic [31:0] d, output logic [31:0] res);
    int n = 0;
    @(negedge clk);
    bus16.in_data = d; bus16.in_mode = m; bus16.in_valid = 1'b1;
    #1;
    while (!bus16.in_ready && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk); @(negedge clk);
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && n < 400) begin @(negedge clk); n++; end
    res = bus16.out_data;
    bus16.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [63:0] r, c, p, d;
    logic [31:0] r16;
    int cyc, lat, stale;

    bus.key_valid = 0; bus.key_in = '0; bus.in_valid = 0; bus.in_mode = 0;
    bus.in_data = '0; bus.out_ready = 0;
    bus16.key_valid = 0; bus16.key_in = '0; bus16.in_valid = 0; bus16.in_mode = 0;
    bus16.in_data = '0; bus16.out_ready = 0;

    // reset state
    #2;
    chk("rst_out", {bus.out_valid, bus.key_loaded, bus.out_data}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    chk("nokey_ready", {bus.key_ready, bus.in_ready}, 128'b10);
    repeat (3) @(negedge clk);
    chk("nokey_hold", {bus.in_ready, bus.out_valid}, 128'b00);
    bus.in_valid = 1'b0;

    // 32/64 variant
    @(negedge clk);
    bus16.key_in = 64'h1918_1110_0908_0100; bus16.key_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.key_valid = 1'b0;
    cyc = 0;
    while (!bus16.key_loaded && cyc < 200) begin @(negedge clk); cyc++; end
    chk("exp16_len", 128'(cyc), 128'(28));
    run16(1'b0, 32'h6565_6877, r16);
    chk("enc16", 128'(r16), 128'(32'hc69b_e9bb));
    run16(1'b1, 32'hc69b_e9bb, r16);
    chk("dec16", 128'(r16), 128'(32'h6565_6877));

    // 64/128 expansion, encrypt, decrypt
    load_key(KEY, cyc);
    chk("expand_len", 128'(cyc), 128'(40));
    run_blk(1'b0, PT, 0, r, lat);
    chk("enc_data", 128'(r), 128'(CT));
    chk("enc_lat", 128'(lat), 128'(44));
    run_blk(1'b1, CT, 0, r, lat);
    chk("dec_data", 128'(r), 128'(PT));
    chk("dec_lat", 128'(lat), 128'(44));

    // backpressure in DONE
    run_blk(1'b0, PT, 10, r, lat);
    chk("bp_data", 128'(r), 128'(CT));

    // key and block together in READY
    @(negedge clk);
    bus.key_in = KEY; bus.key_valid = 1'b1;
    bus.in_data = PT; bus.in_mode = 1'b0; bus.in_valid = 1'b1;
    #1;
    chk("prio_ready", {bus.key_ready, bus.in_ready}, 128'b10);
    @(posedge clk); @(negedge clk);
    bus.key_valid = 1'b0;
    chk("prio_expand", {bus.key_loaded, bus.in_ready, bus.key_ready}, 128'b000);
    cyc = 0;
    while (!bus.key_loaded && cyc < 200) begin @(negedge clk); cyc++; end
    chk("prio_reexpand", 128'(cyc), 128'(40));
    #1;
    chk("prio_blk_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("prio_data", 128'(bus.out_data), 128'(CT));
    chk("prio_lat", 128'(lat), 128'(44));
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;

    // reset at round 20 of a run
    bus.in_data = PT; bus.in_mode = 1'b0; bus.in_valid = 1'b1;
    #1;
    chk("mid_accept", 128'(bus.in_ready), 128'(1));
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", {bus.out_valid, bus.key_loaded, bus.key_ready, bus.in_ready},
        128'b0010);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    stale = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready || bus.out_valid || bus.key_loaded) stale++;
    end
    chk("post_rst_held", 128'(stale), 128'(0));
    bus.in_valid = 1'b0;

    // reload and round trips
    load_key(KEY, cyc);
    chk("reload_len", 128'(cyc), 128'(40));
    for (int i = 0; i < 300; i++) begin
      d = {$urandom, $urandom};
      run_blk(1'b0, d, 0, c, lat);
      run_blk(1'b1, c, 0, p, lat);
      chk("round_trip", 128'(p), 128'(d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
